// File: rtl/mesh_seq_pkg.sv
// Shared types for the mesh test sequencer: command opcodes, FSM states and
// default mesh geometry.
package mesh_seq_pkg;

   typedef enum logic [1:0] {
      OP_PUSH      = 2'd0,
      OP_RUN       = 2'd1,
      OP_SET_DEPTH = 2'd2,
      OP_RSVD      = 2'd3
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_GUARD,
      ST_RUN,
      ST_RD_ADDR,
      ST_RD_WAIT,
      ST_RD_OUT
   } state_e;

   localparam int NODES_DEF     = 16;
   localparam int PMU_WORDS_DEF = 20;

endpackage

// File: rtl/seq_pmu_walker.sv
// PMU readout walker: steps node (outer) and address (inner), drives the
// broadcast PMU address, captures one word per step and offers it on the result handshake.
module seq_pmu_walker
   import mesh_seq_pkg::*;
#(
   parameter int NODES      = NODES_DEF,
   parameter int PMU_ADDR_W = 5,
   parameter int PMU_DATA_W = 64,
   parameter int PMU_WORDS  = PMU_WORDS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  go,
   output logic                  done,
   output logic [PMU_ADDR_W-1:0] pmu_addr,
   input  logic [PMU_DATA_W-1:0] pmu_data [NODES],
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [3:0]            res_node_o,
   output logic [PMU_ADDR_W-1:0] res_addr_o,
   output logic [PMU_DATA_W-1:0] res_data_o,
   output logic                  res_last_o
);

   localparam logic [3:0]            LAST_NODE = 4'(NODES - 1);
   localparam logic [PMU_ADDR_W-1:0] LAST_ADDR = PMU_ADDR_W'(PMU_WORDS - 1);

   state_e                phase;
   logic [3:0]            node_q;
   logic [PMU_ADDR_W-1:0] addr_q;
   logic                  last_word;
   logic                  hs;

   assign last_word = (node_q == LAST_NODE) && (addr_q == LAST_ADDR);
   assign hs        = (phase == ST_RD_OUT) && res_ready_i;
   assign done      = hs && last_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         phase       <= ST_IDLE;
         node_q      <= '0;
         addr_q      <= '0;
         pmu_addr    <= '0;
         res_valid_o <= 1'b0;
         res_node_o  <= '0;
         res_addr_o  <= '0;
         res_data_o  <= '0;
         res_last_o  <= 1'b0;
      end else begin
         case (phase)
            ST_IDLE: begin
               if (go) begin
                  phase    <= ST_RD_ADDR;
                  node_q   <= '0;
                  addr_q   <= '0;
                  pmu_addr <= '0;
               end
            end
            ST_RD_ADDR: phase <= ST_RD_WAIT;
            // PMU data for addr_q is valid by the end of the wait cycle
            ST_RD_WAIT: begin
               phase       <= ST_RD_OUT;
               res_valid_o <= 1'b1;
               res_node_o  <= node_q;
               res_addr_o  <= addr_q;
               res_data_o  <= pmu_data[node_q];
               res_last_o  <= last_word;
            end
            ST_RD_OUT: begin
               if (hs) begin
                  res_valid_o <= 1'b0;
                  if (last_word) begin
                     phase <= ST_IDLE;
                  end else begin
                     phase <= ST_RD_ADDR;
                     if (addr_q == LAST_ADDR) begin
                        addr_q   <= '0;
                        pmu_addr <= '0;
                        node_q   <= node_q + 4'd1;
                     end else begin
                        addr_q   <= addr_q + 1'b1;
                        pmu_addr <= addr_q + 1'b1;
                     end
                  end
               end
            end
            default: phase <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mesh_test_sequencer.sv
// Cycle-exact sequencer for the mesh-with-loaders harness: programs loader
// FIFOs, launches and supervises a run, then streams every node's PMU counters out.
module mesh_test_sequencer
   import mesh_seq_pkg::*;
#(
   parameter int NODES      = NODES_DEF,
   parameter int ID_W       = 5,
   parameter int PMU_ADDR_W = 5,
   parameter int PMU_DATA_W = 64,
   parameter int PMU_WORDS  = PMU_WORDS_DEF,
   parameter int TIMEOUT    = 65535,
   parameter int CYC_W      = 32
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic [1:0]            cmd_op_i,
   input  logic [3:0]            cmd_node_i,
   input  logic [ID_W-1:0]       cmd_id_i,
   input  logic                  cmd_write_i,
   input  logic [7:0]            cmd_axlen_i,
   input  logic [7:0]            cmd_depth_i,
   output logic [7:0]            req_depth_o,
   output logic [ID_W-1:0]       id_o [NODES],
   output logic                  write_o [NODES],
   output logic [7:0]            axlen_o [NODES],
   output logic                  fifo_push_o [NODES],
   output logic                  start_o,
   input  logic                  idle_i [NODES],
   output logic [PMU_ADDR_W-1:0] pmu_addr_o [NODES],
   input  logic [PMU_DATA_W-1:0] pmu_data_i [NODES],
   output logic                  res_valid_o,
   input  logic                  res_ready_i,
   output logic [3:0]            res_node_o,
   output logic [PMU_ADDR_W-1:0] res_addr_o,
   output logic [PMU_DATA_W-1:0] res_data_o,
   output logic                  res_last_o,
   output logic                  busy_o,
   output logic                  timeout_o,
   output logic [CYC_W-1:0]      cycles_o
);

   state_e                state;
   logic                  guard_q;
   logic [ID_W-1:0]       id_q;
   logic                  write_q;
   logic [7:0]            axlen_q;
   logic [NODES-1:0]      push_q;
   logic [NODES-1:0]      idle_vec;
   logic                  all_idle;
   logic                  at_timeout;
   logic                  walk_go;
   logic                  walk_done;
   logic [PMU_ADDR_W-1:0] walk_addr;

   function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   always_comb begin
      idle_vec = '0;
      for (int i = 0; i < NODES; i++) begin
         idle_vec[i]    = idle_i[i];
         id_o[i]        = id_q;
         write_o[i]     = write_q;
         axlen_o[i]     = axlen_q;
         fifo_push_o[i] = push_q[i];
         pmu_addr_o[i]  = walk_addr;
      end
   end

   assign all_idle    = &idle_vec;
   assign at_timeout  = (cycles_o == CYC_W'(TIMEOUT - 1));
   assign walk_go     = (state == ST_RUN) && (all_idle || at_timeout);
   assign cmd_ready_o = (state == ST_IDLE);
   assign busy_o      = (state != ST_IDLE);

   always_ff @(posedge aclk) begin
      if (areset) begin
         state       <= ST_IDLE;
         guard_q     <= 1'b0;
         id_q        <= '0;
         write_q     <= 1'b0;
         axlen_q     <= '0;
         push_q      <= '0;
         start_o     <= 1'b0;
         req_depth_o <= '0;
         timeout_o   <= 1'b0;
         cycles_o    <= '0;
      end else begin
         push_q  <= '0;
         start_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  case (op_e'(cmd_op_i))
                     OP_PUSH: begin
                        id_q    <= cmd_id_i;
                        write_q <= cmd_write_i;
                        axlen_q <= cmd_axlen_i;
                        if (32'(cmd_node_i) < NODES) push_q[cmd_node_i] <= 1'b1;
                     end
                     OP_SET_DEPTH: req_depth_o <= cmd_depth_i;
                     OP_RUN: begin
                        state     <= ST_START;
                        start_o   <= 1'b1;
                        timeout_o <= 1'b0;
                        cycles_o  <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_START: begin
               state   <= ST_GUARD;
               guard_q <= 1'b0;
            end
            // loaders need two cycles to drop idle after start
            ST_GUARD: begin
               if (guard_q) state <= ST_RUN;
               else         guard_q <= 1'b1;
            end
            ST_RUN: begin
               cycles_o <= sat_inc(cycles_o);
               if (all_idle) begin
                  state <= ST_RD_ADDR;
               end else if (at_timeout) begin
                  timeout_o <= 1'b1;
                  state     <= ST_RD_ADDR;
               end
            end
            // the walker sequences the per-word phases; this state spans the whole readout
            ST_RD_ADDR: if (walk_done) state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   seq_pmu_walker #(
      .NODES      (NODES),
      .PMU_ADDR_W (PMU_ADDR_W),
      .PMU_DATA_W (PMU_DATA_W),
      .PMU_WORDS  (PMU_WORDS)
   ) u_walker (
      .clk         (aclk),
      .rst         (areset),
      .go          (walk_go),
      .done        (walk_done),
      .pmu_addr    (walk_addr),
      .pmu_data    (pmu_data_i),
      .res_valid_o (res_valid_o),
      .res_ready_i (res_ready_i),
      .res_node_o  (res_node_o),
      .res_addr_o  (res_addr_o),
      .res_data_o  (res_data_o),
      .res_last_o  (res_last_o)
   );

endmodule

// File: tb/tb_mesh_test_sequencer.sv
// Directed/randomized bench for mesh_test_sequencer with a PMU model and a
// behavioural expectation of run length, timeout and readout order.
module tb_mesh_test_sequencer;

   localparam int N   = 16;
   localparam int W   = 20;
   localparam int TO  = 50;
   localparam int TOT = N * W;

   logic        aclk = 1'b0;
   logic        areset;
   logic        cmd_valid_i, cmd_ready_o;
   logic [1:0]  cmd_op_i;
   logic [3:0]  cmd_node_i;
   logic [4:0]  cmd_id_i;
   logic        cmd_write_i;
   logic [7:0]  cmd_axlen_i, cmd_depth_i, req_depth_o;
   logic [4:0]  id_o [N];
   logic        write_o [N];
   logic [7:0]  axlen_o [N];
   logic        fifo_push_o [N];
   logic        start_o;
   logic        idle_i [N];
   logic [4:0]  pmu_addr_o [N];
   logic [63:0] pmu_data_i [N];
   logic        res_valid_o, res_ready_i;
   logic [3:0]  res_node_o;
   logic [4:0]  res_addr_o;
   logic [63:0] res_data_o;
   logic        res_last_o, busy_o, timeout_o;
   logic [31:0] cycles_o;

   int          tests = 0;
   int          fails = 0;
   logic [31:0] pmu_tag = 32'h0;

   mesh_test_sequencer #(.TIMEOUT(TO)) dut (
      .aclk(aclk), .areset(areset),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_op_i(cmd_op_i),
      .cmd_node_i(cmd_node_i), .cmd_id_i(cmd_id_i), .cmd_write_i(cmd_write_i),
      .cmd_axlen_i(cmd_axlen_i), .cmd_depth_i(cmd_depth_i), .req_depth_o(req_depth_o),
      .id_o(id_o), .write_o(write_o), .axlen_o(axlen_o), .fifo_push_o(fifo_push_o),
      .start_o(start_o), .idle_i(idle_i), .pmu_addr_o(pmu_addr_o), .pmu_data_i(pmu_data_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_node_o(res_node_o),
      .res_addr_o(res_addr_o), .res_data_o(res_data_o), .res_last_o(res_last_o),
      .busy_o(busy_o), .timeout_o(timeout_o), .cycles_o(cycles_o)
   );

   always #5 aclk = ~aclk;

   // PMU model: one-cycle registered read, contents encode tag/node/address
   always @(posedge aclk)
      for (int n = 0; n < N; n++)
         pmu_data_i[n] <= {pmu_tag, 16'(n), 11'd0, pmu_addr_o[n]};

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] push_vec();
      logic [15:0] v;
      for (int i = 0; i < N; i++) v[i] = fifo_push_o[i];
      return v;
   endfunction

   function automatic logic [73:0] exp_word(input int idx, input logic [31:0] tg);
      int n, a;
      n = idx / W;
      a = idx % W;
      return {4'(n), 5'(a), tg, 16'(n), 16'(a), idx == TOT - 1};
   endfunction

   task automatic set_idle(input bit all_hi, input int low_node);
      for (int i = 0; i < N; i++) idle_i[i] = 1'b1;
      if (!all_hi) idle_i[low_node] = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_busy"}, busy_o, 1'b0);
      check({tag, "_ready"}, cmd_ready_o, 1'b1);
      check({tag, "_strobes"}, {push_vec(), start_o, res_valid_o}, 18'd0);
      check({tag, "_stat"}, {timeout_o, cycles_o, req_depth_o}, 41'd0);
      check({tag, "_desc"}, {id_o[0], write_o[7], axlen_o[15], pmu_addr_o[3]}, 19'd0);
      check({tag, "_res"}, {res_node_o, res_addr_o, res_data_o, res_last_o}, 74'd0);
   endtask

   // Issue RUN; loaders look busy (idle_i[low_node]=0) for d RUN cycles after GUARD,
   // so the run should last min(d+1, TO) counted cycles.
   task automatic run_case(input string tag, input int d, input int low_node, input bit bp);
      int          k, got, exp_c;
      bit          exp_to, stalled, rdy;
      logic [73:0] payload, prev;
      exp_c   = (d + 1 < TO) ? d + 1 : TO;
      exp_to  = (d + 1 > TO);
      got     = 0;
      stalled = 0;
      prev    = '0;
      pmu_tag = $urandom;
      set_idle(1'b1, 0);
      res_ready_i = 1'b0;
      check({tag, "_ready_pre"}, cmd_ready_o, 1'b1);
      cmd_op_i    = 2'd1;
      cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      check({tag, "_start"}, {start_o, busy_o}, 2'b11);
      k = 0;
      while (k < 5000) begin
         set_idle((k < 3) || (k >= 3 + d), low_node);
         if (k == 1) check({tag, "_start_pulse"}, {start_o, cmd_ready_o}, 2'b00);
         if (res_valid_o) begin
            payload = {res_node_o, res_addr_o, res_data_o, res_last_o};
            if (stalled) check({tag, "_stable"}, payload, prev);
            rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (rdy) begin
               check({tag, "_word"}, payload, exp_word(got, pmu_tag));
               got++;
               stalled = 0;
            end else begin
               stalled = 1;
               prev    = payload;
            end
         end else begin
            if (stalled) check({tag, "_valid_held"}, res_valid_o, 1'b1);
            stalled = 0;
            rdy = bp ? $urandom_range(0, 1) : 1'b1;
         end
         res_ready_i = rdy;
         tick();
         k++;
         if (!busy_o) break;
      end
      res_ready_i = 1'b0;
      check({tag, "_finished"}, busy_o, 1'b0);
      check({tag, "_count"}, got, TOT);
      check({tag, "_cycles"}, cycles_o, exp_c);
      check({tag, "_timeout"}, timeout_o, exp_to);
      check({tag, "_valid_end"}, res_valid_o, 1'b0);
      if (!bp) check({tag, "_length"}, k, 3 + exp_c + 3 * TOT);
   endtask

   initial begin
      int          node;
      logic [4:0]  id;
      logic        wr;
      logic [7:0]  len;

      areset = 1'b1;
      cmd_valid_i = 1'b0; cmd_op_i = 2'd0; cmd_node_i = '0; cmd_id_i = '0;
      cmd_write_i = 1'b0; cmd_axlen_i = '0; cmd_depth_i = '0; res_ready_i = 1'b0;
      set_idle(1'b1, 0);
      tick();
      tick();
      check_reset_vals("reset");
      areset = 1'b0;
      tick();

      // directed PUSH
      cmd_op_i = 2'd0; cmd_node_i = 4'd3; cmd_id_i = 5'd5; cmd_write_i = 1'b1; cmd_axlen_i = 8'd7;
      cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      check("push3_vec", push_vec(), 16'h0008);
      check("push3_desc", {id_o[0], write_o[9], axlen_o[15]}, {5'd5, 1'b1, 8'd7});
      tick();
      check("push3_one_cycle", push_vec(), 16'h0000);

      // back-to-back random PUSHes
      cmd_valid_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         node = $urandom_range(0, N - 1);
         id   = 5'($urandom);
         wr   = 1'($urandom);
         len  = 8'($urandom);
         cmd_node_i = 4'(node); cmd_id_i = id; cmd_write_i = wr; cmd_axlen_i = len;
         tick();
         check("push_rand_vec", push_vec(), 16'(1) << node);
         check("push_rand_desc", {id_o[node], write_o[N-1-node], axlen_o[i]}, {id, wr, len});
      end
      cmd_valid_i = 1'b0;
      tick();
      check("push_rand_end", push_vec(), 16'h0000);

      // SET_DEPTH then a reserved op that must be dropped
      cmd_op_i = 2'd2; cmd_depth_i = 8'd4; cmd_valid_i = 1'b1;
      tick();
      check("set_depth", req_depth_o, 8'd4);
      cmd_op_i = 2'd3; cmd_depth_i = 8'd9;
      tick();
      cmd_valid_i = 1'b0;
      check("rsvd_drop", {req_depth_o, busy_o, push_vec()}, {8'd4, 1'b0, 16'h0000});

      run_case("run_idle", 0, 0, 1'b0);
      check("depth_kept", req_depth_o, 8'd4);
      run_case("run_node9", 99, 9, 1'b0);
      run_case("run_stuck", 200, 0, 1'b1);
      run_case("run_tie", TO - 1, 5, 1'b0);
      run_case("run_over", TO, 12, 1'b0);
      run_case("run_rand", $urandom_range(0, 30), $urandom_range(0, N - 1), 1'b1);

      // reset in the middle of a readout with a word pending
      pmu_tag = $urandom;
      cmd_op_i = 2'd1; cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      for (int i = 0; i < 30; i++) tick();
      check("mid_valid", res_valid_o, 1'b1);
      areset = 1'b1;
      tick();
      areset = 1'b0;
      check_reset_vals("mid_reset");
      res_ready_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("post_reset_quiet", {res_valid_o, start_o, busy_o, push_vec()}, 19'd0);
      end
      res_ready_i = 1'b0;
      run_case("run_after_reset", 3, 2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mesh_test_sequencer.md
# mesh_test_sequencer

Cosimulation control stage that sits directly upstream of the 16-node mesh-with-loaders harness. It accepts a command stream that programs per-node loader FIFOs and launches a run, then supervises the run until every loader reports idle or a timeout fires. It then walks every node's PMU counter window and streams the counter values out as a result stream. It replaces testbench-side poking of the loader and PMU arrays with one cycle-exact hardware sequencer.

## Interface
Parameters:
- NODES, 16, number of mesh nodes/loaders/PMUs
- ID_W, 5, loader transaction id width
- PMU_ADDR_W, 5, PMU register address width
- PMU_DATA_W, 64, PMU counter width
- PMU_WORDS, 20, counters read per node (addresses 0..PMU_WORDS-1)
- TIMEOUT, 65535, max run cycles before abort
- CYC_W, 32, run-cycle counter width

Ports:
- aclk  in  1  clock; everything is sampled on the rising edge.
- areset  in  1  reset; one clock; reset is synchronous and active-high.
- cmd_valid_i / cmd_ready_o  in/out  1  command handshake.
- cmd_op_i  in  2  0=PUSH, 1=RUN, 2=SET_DEPTH, 3=reserved.
- cmd_node_i  in  4  target node for PUSH.
- cmd_id_i  in  ID_W; cmd_write_i  in  1; cmd_axlen_i  in  8  PUSH descriptor fields.
- cmd_depth_i  in  8  SET_DEPTH value.
- req_depth_o  out  8  to all loaders.
- id_o[NODES]  out  ID_W; write_o[NODES]  out  1; axlen_o[NODES]  out  8  descriptor fields, broadcast to all nodes.
- fifo_push_o[NODES]  out  1  one-hot push strobe.
- start_o  out  1  run-start pulse.
- idle_i[NODES]  in  1  loader idle flags.
- pmu_addr_o[NODES]  out  PMU_ADDR_W; pmu_data_i[NODES]  in  PMU_DATA_W  PMU read port.
- res_valid_o / res_ready_i  out/in  1  result handshake.
- res_node_o  out  4; res_addr_o  out  PMU_ADDR_W; res_data_o  out  PMU_DATA_W; res_last_o  out  1  result payload.
- busy_o  out  1  high in any state other than IDLE.
- timeout_o  out  1  sticky abort flag.
- cycles_o  out  CYC_W  run length.

## Operation
- FSM states: IDLE, START, GUARD, RUN, RD_ADDR, RD_WAIT, RD_OUT.
- IDLE: cmd_ready_o=1.
  - PUSH: on handshake, register id/write/axlen. fifo_push_o[cmd_node_i] is high for exactly the next cycle. A cmd_node_i ≥ NODES is consumed with no push.
  - SET_DEPTH: req_depth_o←cmd_depth_i, next cycle.
  - Reserved op: consumed and dropped.
  - RUN: go to START; clear timeout_o and cycles_o.
- START: start_o=1 for one cycle → GUARD.
- GUARD: 2 cycles in which idle_i is ignored, covering loader idle deassertion latency → RUN.
- RUN: cycles_o increments each cycle and saturates at all-ones.
  - AND of idle_i → RD_ADDR.
  - Otherwise, when the cycle count reaches TIMEOUT: set timeout_o, then RD_ADDR. Loaders are not reset.
- Readout walks node n=0..NODES-1 (outer loop) and address a=0..PMU_WORDS-1 (inner loop). For each word:
  - RD_ADDR: drive pmu_addr_o[*]=a (broadcast).
  - RD_WAIT: one cycle for PMU read latency.
  - RD_OUT: capture pmu_data_i[n] into res_data_o; res_valid_o=1 and the payload is held stable until res_ready_i.
  - res_last_o=1 only for n=NODES-1, a=PMU_WORDS-1. After that handshake → IDLE.
- cmd_ready_o=0 outside IDLE; commands are never dropped silently while busy, they simply stall.

## Timing
- Reset values:
  - all strobes/valids 0, busy_o 0, timeout_o 0, cycles_o 0, req_depth_o 0.
  - id_o/write_o/axlen_o 0, pmu_addr_o 0, res_* 0.
  - State IDLE.
- Reset mid-run or mid-readout aborts immediately. No further push/start/valid is issued after the reset cycle.
- Latency from RUN handshake to start_o: 1 cycle. The first possible RD_ADDR is 4 cycles after the handshake.
- cycles_o counts RUN-state cycles only.
- Per-word readout takes 3 cycles plus res_ready_i stall. With res_ready_i tied high, a full readout is NODES·PMU_WORDS·3 cycles.
- All idle and timeout in the same cycle: the idle path wins and timeout_o stays 0.
- res_valid_o never drops without a handshake. res_ready_i high before valid has no effect.

## Structure
- Package mesh_seq_pkg holds:
  - op enum (OP_PUSH, OP_RUN, OP_SET_DEPTH, OP_RSVD)
  - state enum
  - NODES and PMU_WORDS defaults.
- Sub-module seq_pmu_walker owns the node/addr counters, PMU address drive, the capture register and the result handshake. It is started by a one-cycle go pulse and reports done.

## Test plan
- PUSH node 3, id 5, write 1, axlen 7 → fifo_push_o[3] high exactly one cycle, id_o=5, axlen_o=7; all other pushes 0.
- SET_DEPTH 4 then RUN with all idle_i held high → start_o one cycle; readout begins after GUARD; cycles_o=1, timeout_o=0.
- RUN with idle_i[9] low for 100 cycles → cycles_o=100 (±GUARD alignment documented), followed by 320 results with res_last_o on node 15 addr 19.
- TIMEOUT=50 with idle_i[0] stuck low → timeout_o=1 after 50 RUN cycles; readout still completes; the next RUN clears timeout_o.
- Random res_ready_i backpressure → payload stable while stalled; no lost or duplicated (node, addr) pairs.
- areset asserted mid-readout → next cycle all outputs at reset values; cmd_ready_o=1; a fresh RUN works normally.
